accum_feeder: RTL and testbench
===============================

# accum_feeder

Upstream stream source for the gated accumulator FSMD: buffers (data, keep) entries in a small FIFO and, on command, replays them onto the accumulator's `start`, `inputC`, `inputB` and `inputA` inputs. The replay follows the accumulator's two-cycle check-C / check-B cadence.
- `inputC` high means "another element follows".
- `inputB` gates the add of `inputA`.

The stream ends with `inputC` low once the FIFO is empty. The block sits directly in front of the accumulator, sharing its clock and reset.

## Interface
Parameters:
- `W`, 8, data width; matches the accumulator's `W`.
- `AW`, 2, FIFO address width; depth = 2^AW entries.

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset_L`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  push {`wr_keep`, `wr_data`} into FIFO this cycle.
- `wr_data`  in  W  element value.
- `wr_keep`  in  1  1 = element is added by the accumulator, 0 = skipped.
- `go`  in  1  begin replay; sampled only in IDLE.
- `start`  out  1  one-cycle start pulse to the accumulator.
- `inputC`  out  1  continue flag to the accumulator.
- `inputB`  out  1  add-enable to the accumulator.
- `inputA`  out  W  element value to the accumulator.
- `full`  out  1  FIFO holds 2^AW entries.
- `empty`  out  1  FIFO holds 0 entries.
- `busy`  out  1  state is START, PH_C or PH_B.
- `finished`  out  1  state is END.
- `overflow`  out  1  sticky; a write was dropped.
- `fed_count`  out  W  elements presented in PH_B, modulo 2^W.

## Operation
- **FIFO:** circular buffer, 2^AW entries of W+1 bits, with an occupancy counter of AW+1 bits.
  - Push when `wr_en` and not `full`. A write while `full` is dropped and sets `overflow`, even if a pop occurs the same cycle.
  - A pop and a non-full push in the same cycle are both performed; occupancy is unchanged.
  - Pointers wrap modulo 2^AW.
- **States:** IDLE, START, PH_C, PH_B, END.
- **Transitions:**
  - IDLE → START: when `go` and not `empty`. Otherwise stay in IDLE; `go` with an empty FIFO is ignored.
  - START → PH_C: unconditional.
  - PH_C → PH_B: if not `empty`; otherwise → END.
  - PH_B → PH_C: unconditional; pops the head entry at the clock edge ending PH_B.
  - END → END: END holds until reset, because the accumulator's stop state is also terminal.
- **Outputs** are functions of registered state and FIFO contents only; there is no combinational path from `go` or `wr_*`.
  - `start` = 1 only in START.
  - `inputC` = ~`empty` in PH_C; 0 in all other states.
  - In PH_B, `inputB` = head keep and `inputA` = head data. In all other states both are 0.
- **fed_count:** increments at the end of every PH_B cycle and wraps at 2^W.
- **Writes during replay:** permitted at any time. An entry written before the PH_C cycle samples `empty` extends the stream.
- **go outside IDLE:** ignored.

## Timing
- **Reset values:** state IDLE, FIFO empty, pointers 0. Outputs: `start`=0, `inputC`=0, `inputB`=0, `inputA`=0, `full`=0, `empty`=1, `busy`=0, `finished`=0, `overflow`=0, `fed_count`=0.
- **Reset mid-operation:** reset asynchronously returns all of the above; FIFO contents are discarded.
- **Replay latency:**
  - `go` is sampled at edge k; `start` is high in cycle k+1.
  - The first PH_C is cycle k+2.
  - Element i is presented in PH_B at cycle k+3+2i.
- **Stream length:** N queued elements give a stream of 2N+2 cycles (START through the final PH_C), with END from cycle k+2N+3.
- **Sampling rule:** `empty` in PH_C reflects occupancy at the start of the cycle; a same-cycle write does not count.
- **Phase alignment:** this matches the accumulator exactly. It enters check-C the cycle after `start` and alternates check-C / check-B thereafter.

## Test plan
1. **Reset:** assert `reset_L`=0 mid-cycle → all outputs at reset values immediately; `empty`=1.
2. **Basic replay:** W=8. Write (5,1), (7,0), (9,1); pulse `go` at edge 0.
   - Expect `start` in cycle 1.
   - `inputC`=1 in cycles 2, 4, 6.
   - (`inputB`, `inputA`) = (1,5), (0,7), (1,9) in cycles 3, 5, 7.
   - `inputC`=0 in cycle 8; `finished`=1 from cycle 9; `fed_count`=3.
   - Attached accumulator `value`=14 and `done`=1.
3. **Empty go:** `go` with an empty FIFO → no `start`; state stays IDLE; `busy`=0.
4. **Overflow:** AW=2. Write 4 entries → `full`=1. Fifth write → dropped, `overflow`=1, occupancy 4. A write plus a pop while full → write still dropped.
5. **Extension:** queue (3,1) and `go`. Write (4,1) during the first PH_B → second PH_C has `inputC`=1, element (1,4) follows, accumulator `value`=7.
6. **Reset mid-replay:** reset during a PH_B → IDLE, `empty`=1, `fed_count`=0. A new write plus `go` replays normally.

Source files
------------

// File: rtl/accum_feeder.sv
`default_nettype none
// ============================================================================
// Module   : accum_feeder
// Purpose  : Stream source for the gated accumulator FSMD. Buffers
//            (data, keep) entries in a small circular FIFO and, on `go`,
//            replays them in the accumulator's check-C / check-B cadence:
//            START pulse, then PH_C (continue flag) / PH_B (keep + data)
//            pairs until the FIFO is found empty in PH_C, then END.
// Ports    :
//   clock, reset_L          - rising-edge clock, async active-low reset
//   wr_en/wr_data/wr_keep   - FIFO push of {keep, data}
//   go                      - begin replay (IDLE only)
//   start,inputC,inputB,inputA - accumulator drive
//   full, empty, overflow   - FIFO status (overflow sticky)
//   busy, finished          - replay in progress / terminal END state
//   fed_count               - elements presented in PH_B, modulo 2^W
// Revision : 1.0 - initial release
// ============================================================================
module accum_feeder #(
    parameter int W  = 8,
    parameter int AW = 2
) (
    input  logic         clock,
    input  logic         reset_L,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         wr_keep,
    input  logic         go,
    output logic         start,
    output logic         inputC,
    output logic         inputB,
    output logic [W-1:0] inputA,
    output logic         full,
    output logic         empty,
    output logic         busy,
    output logic         finished,
    output logic         overflow,
    output logic [W-1:0] fed_count
);

    localparam int            c_DEPTH    = 1 << AW;
    localparam logic [AW:0]   c_FULL_CNT = (AW+1)'(c_DEPTH);
    localparam logic [AW:0]   c_CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] c_PTR_ONE  = AW'(1);
    localparam logic [W-1:0]  c_FED_ONE  = W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_PH_C  = 3'd2,
        S_PH_B  = 3'd3,
        S_END   = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic [W:0]    r_mem [c_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [W-1:0]  r_fed;
    logic          r_ovf;

    logic          w_push;
    logic          w_pop;
    logic [W:0]    w_head;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    assign full   = (r_count == c_FULL_CNT);
    assign empty  = (r_count == '0);
    // Fullness is judged at the start of the cycle, so a write while full
    // is dropped even when the head is popped on the same edge.
    assign w_push = wr_en & ~full;
    // PH_B is only entered with a non-empty FIFO; the guard is defensive.
    assign w_pop  = (r_state == S_PH_B) & ~empty;
    assign w_head = r_mem[r_rd_ptr];

    // Storage needs no reset: nothing is read unless occupancy says valid.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {wr_keep, wr_data};
        end
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (wr_en && full) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Replay FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            r_state <= S_IDLE;
            r_fed   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_PH_B) begin
                r_fed <= r_fed + c_FED_ONE;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (go && !empty) w_next = S_START;
            S_START: w_next = S_PH_C;
            S_PH_C:  w_next = empty ? S_END : S_PH_B;
            S_PH_B:  w_next = S_PH_C;
            // Terminal, mirroring the accumulator's stop state.
            S_END:   w_next = S_END;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs depend only on registered state and FIFO contents.
    always_comb begin
        start  = 1'b0;
        inputC = 1'b0;
        inputB = 1'b0;
        inputA = '0;
        case (r_state)
            S_START: start  = 1'b1;
            S_PH_C:  inputC = ~empty;
            S_PH_B: begin
                inputB = w_head[W];
                inputA = w_head[W-1:0];
            end
            default: ;
        endcase
    end

    assign busy      = (r_state == S_START) || (r_state == S_PH_C) ||
                       (r_state == S_PH_B);
    assign finished  = (r_state == S_END);
    assign overflow  = r_ovf;
    assign fed_count = r_fed;

endmodule
`default_nettype wire

// File: tb/tb_accum_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_accum_feeder
// Purpose  : Self-checking bench for accum_feeder. A queue models the FIFO;
//            replay expectations come from walking that queue element by
//            element (start, then continue/element pairs, then end).
// Revision : 1.0 - initial release
// ============================================================================
module tb_accum_feeder;

    localparam int W     = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    logic         clock   = 1'b0;
    logic         reset_L = 1'b0;
    logic         wr_en   = 1'b0;
    logic [W-1:0] wr_data = '0;
    logic         wr_keep = 1'b0;
    logic         go      = 1'b0;
    logic         start, inputC, inputB, full, empty, busy, finished, overflow;
    logic [W-1:0] inputA, fed_count;

    accum_feeder #(.W(W), .AW(AW)) dut (
        .clock     (clock),
        .reset_L   (reset_L),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .wr_keep   (wr_keep),
        .go        (go),
        .start     (start),
        .inputC    (inputC),
        .inputB    (inputB),
        .inputA    (inputA),
        .full      (full),
        .empty     (empty),
        .busy      (busy),
        .finished  (finished),
        .overflow  (overflow),
        .fed_count (fed_count)
    );

    always #5 clock = ~clock;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [W:0] q[$];
    bit         m_ovf   = 1'b0;
    int         m_fed   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_fifo(input string tag);
        chk({tag, "_full"},  full,     (q.size() == DEPTH) ? 1 : 0);
        chk({tag, "_empty"}, empty,    (q.size() == 0) ? 1 : 0);
        chk({tag, "_ovf"},   overflow, m_ovf);
    endtask

    // One clock: drive inputs, advance the model at the edge, sample at +1.
    task automatic cyc(input logic we, input logic [W:0] ent, input logic g, input logic pop);
        bit was_full;
        wr_en   = we;
        wr_keep = ent[W];
        wr_data = ent[W-1:0];
        go      = g;
        @(posedge clock);
        was_full = (q.size() == DEPTH);
        if (pop) begin
            q.delete(0);
            m_fed = (m_fed + 1) % (1 << W);
        end
        if (we) begin
            if (was_full) m_ovf = 1'b1;
            else          q.push_back(ent);
        end
        #1;
        wr_en = 1'b0; wr_keep = 1'b0; wr_data = '0; go = 1'b0;
    endtask

    task automatic do_reset();
        #2 reset_L = 1'b0;
        #1;
        q.delete();
        m_ovf = 1'b0;
        m_fed = 0;
        chk("rst_start",    start,     0);
        chk("rst_inputC",   inputC,    0);
        chk("rst_inputB",   inputB,    0);
        chk("rst_inputA",   inputA,    0);
        chk("rst_full",     full,      0);
        chk("rst_empty",    empty,     1);
        chk("rst_busy",     busy,      0);
        chk("rst_finished", finished,  0);
        chk("rst_overflow", overflow,  0);
        chk("rst_fed",      fed_count, 0);
        @(negedge clock);
        reset_L = 1'b1;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [W:0] rnd_ent();
        logic [W:0] e;
        e[W]     = 1'($urandom_range(0, 1));
        e[W-1:0] = W'($urandom_range(0, (1 << W) - 1));
        return e;
    endfunction

    // policy 0: no writes during replay; 1: random writes; 2: write (1,4)
    // during the first PH_B.
    task automatic replay(input int policy, output int sum_obs, output int sum_exp);
        int         guard;
        bit         was_empty, exp_c, first_b;
        int         nwr;
        logic       we;
        logic [W:0] ent, head;
        sum_obs   = 0;
        sum_exp   = 0;
        nwr       = 0;
        guard     = 0;
        first_b   = 1'b1;
        was_empty = (q.size() == 0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        if (was_empty) begin
            chk("idle_start", start, 0);
            chk("idle_busy",  busy,  0);
            cyc(1'b0, '0, 1'b0, 1'b0);
            chk("idle_start2", start, 0);
            chk("idle_busy2",  busy,  0);
            return;
        end
        chk("start_pulse", start,  1);
        chk("start_busy",  busy,   1);
        chk("start_c",     inputC, 0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        forever begin
            exp_c = (q.size() != 0);
            chk("phc_c",     inputC, exp_c);
            chk("phc_b",     inputB, 0);
            chk("phc_start", start,  0);
            chk("phc_busy",  busy,   1);
            chk_fifo("phc");
            we  = (policy == 1) && (nwr < 3) && ($urandom_range(0, 2) == 0);
            ent = rnd_ent();
            if (we) nwr++;
            cyc(we, ent, 1'b0, 1'b0);
            if (!exp_c) break;
            head = q[0];
            chk("phb_b",    inputB, head[W]);
            chk("phb_a",    inputA, head[W-1:0]);
            chk("phb_c",    inputC, 0);
            chk("phb_busy", busy,   1);
            if (inputB)  sum_obs += int'(inputA);
            if (head[W]) sum_exp += int'(head[W-1:0]);
            if (policy == 2) begin
                we  = first_b;
                ent = {1'b1, W'(4)};
            end else begin
                we  = (policy == 1) && (nwr < 3) && ($urandom_range(0, 2) == 0);
                ent = rnd_ent();
                if (we) nwr++;
            end
            first_b = 1'b0;
            cyc(we, ent, 1'b0, 1'b1);
            guard++;
            if (guard > 40) begin
                chk("replay_timeout", 0, 1);
                break;
            end
        end
        chk("end_finished", finished,  1);
        chk("end_busy",     busy,      0);
        chk("end_c",        inputC,    0);
        chk("end_fed",      fed_count, m_fed);
        // go outside IDLE must be ignored, even with data queued
        cyc(1'b1, {1'b1, W'(8'hAA)}, 1'b1, 1'b0);
        chk("end_go_start", start,    0);
        chk("end_go_fin",   finished, 1);
        chk_fifo("end");
    endtask

    initial begin
        int s, e, n;
        reset_L = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        do_reset();
        chk_fifo("post_rst");

        // Basic replay: (5,1) (7,0) (9,1) -> sum 14, three elements fed
        cyc(1'b1, {1'b1, W'(5)}, 1'b0, 1'b0);
        cyc(1'b1, {1'b0, W'(7)}, 1'b0, 1'b0);
        cyc(1'b1, {1'b1, W'(9)}, 1'b0, 1'b0);
        replay(0, s, e);
        chk("basic_sum", s, 14);
        chk("basic_fed", fed_count, 3);

        // go with empty FIFO is ignored
        do_reset();
        replay(0, s, e);
        chk("emptygo_fin", finished, 0);

        // Overflow: fill, drop a fifth write, drop a write coinciding with a pop
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b1, rnd_ent(), 1'b0, 1'b0);
        end
        chk("ovf_full", full, 1);
        chk("ovf_none", overflow, 0);
        cyc(1'b1, rnd_ent(), 1'b0, 1'b0);
        chk("ovf_set",   overflow, 1);
        chk("ovf_full2", full, 1);
        replay(2, s, e);
        chk("ovf_sum",    s, e);
        chk("ovf_fed",    fed_count, DEPTH);
        chk("ovf_sticky", overflow, 1);

        // Extension: (3,1) queued, (4,1) written during first PH_B -> sum 7
        do_reset();
        cyc(1'b1, {1'b1, W'(3)}, 1'b0, 1'b0);
        replay(2, s, e);
        chk("ext_sum", s, 7);
        chk("ext_fed", fed_count, 2);

        // Reset during PH_B, then a fresh replay
        do_reset();
        cyc(1'b1, {1'b1, W'(11)}, 1'b0, 1'b0);
        cyc(1'b1, {1'b1, W'(12)}, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        chk("mid_phc_c", inputC, 1);
        cyc(1'b0, '0, 1'b0, 1'b0);
        chk("mid_phb_b", inputB, 1);
        do_reset();
        cyc(1'b1, {1'b1, W'(6)}, 1'b0, 1'b0);
        replay(0, s, e);
        chk("mid_sum", s, 6);
        chk("mid_fed", fed_count, 1);

        // Randomized trials
        for (int t = 0; t < 8; t++) begin
            do_reset();
            n = $urandom_range(1, 7);
            for (int j = 0; j < n; j++) begin
                cyc(($urandom_range(0, 3) != 0), rnd_ent(), 1'b0, 1'b0);
                chk_fifo("rnd_fill");
            end
            replay(1, s, e);
            chk("rnd_sum", s, e);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
